// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the encoder.
// No latency of its own; it only bundles wires.
// Backpressure travels on in_ready, from the encoder back to the loader.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;
  logic              full;

  // Loader side: drives the fields and observes the write port.
  modport master (
    output in_valid, op_sel, rd, rs1, rs2, imm, clear,
    input  in_ready, wr_en, wr_addr, wr_data, err, err_code, word_count, full
  );

  // Encoder side.
  modport slave (
    input  in_valid, op_sel, rd, rs1, rs2, imm, clear,
    output in_ready, wr_en, wr_addr, wr_data, err, err_code, word_count, full
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field encoder that also writes the program image to imem at an auto-incrementing address.
// Latency: a bundle accepted at edge N gives wr_en or err during cycle N+1; one bundle per 2 cycles.
// Backpressure: in_ready drops while emitting, while clear is high, and while the image is full.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst_n,
  instr_encoder_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;
  localparam int         DEPTH = 1 << ADDR_W;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              wr_q;
  logic              err_q;
  logic [31:0]       data_q;
  logic [1:0]        code_q;

  logic              accept;
  logic              is_full;
  logic              bad;
  logic [31:0]       word;
  logic [1:0]        code;
  logic signed [31:0] imm_s;
  logic              i_ok;
  logic              b_ok;

  assign is_full      = (cnt == (ADDR_W+1)'(DEPTH));
  assign bus.in_ready = (state == IDLE) && !is_full && !bus.clear;
  assign accept       = bus.in_valid && bus.in_ready;

  assign imm_s = $signed(bus.imm);
  assign i_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign b_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);

  // Pack the live fields and classify them; priority is illegal op, then misalignment, then range.
  always_comb begin
    word = '0;
    code = 2'b00;
    case (bus.op_sel)
      3'd0: begin
        word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
        if (!i_ok) code = 2'b10;
      end
      3'd1: begin
        word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
        if (!i_ok) code = 2'b10;
      end
      3'd2: begin
        word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
        if (!i_ok) code = 2'b10;
      end
      3'd3: begin
        word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                bus.imm[4:1], bus.imm[11], 7'b1100011};
        if (bus.imm[0])  code = 2'b11;
        else if (!b_ok)  code = 2'b10;
      end
      3'd4: word = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      3'd5: word = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      default: code = 2'b01;
    endcase
  end

  assign bad = (code != 2'b00);

  // Two-state FSM; the encoded result is captured at accept so the EMIT cycle presents registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      code_q <= 2'b00;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= EMIT;
            wr_q  <= !bad;
            err_q <= bad;
            if (bad) code_q <= code;
            else     data_q <= word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write pointer and count advance as the EMIT cycle ends; clear takes precedence over the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (bus.clear) begin
      ptr <= '0;
      cnt <= '0;
    end else if (state == EMIT && wr_q) begin
      ptr <= ptr + ADDR_W'(1);
      cnt <= cnt + (ADDR_W+1)'(1);
    end
  end

  // Strobes are masked by rst_n so that a reset landing in EMIT never writes memory.
  assign bus.wr_en      = wr_q && rst_n;
  assign bus.err        = err_q && rst_n;
  assign bus.wr_addr    = ptr;
  assign bus.wr_data    = data_q;
  assign bus.err_code   = code_q;
  assign bus.word_count = cnt;
  assign bus.full       = is_full;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder with a field-level reference model.
// Stimulus pushes expectations at accept; an independent monitor pops them on wr_en/err.
// Directed cases cover the documented encodings, errors, full, clear and reset in EMIT.
module tb_instr_encoder;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   model_ptr;
  int   model_cnt;
  exp_t sb[$];

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
  endtask

  // Reference model: builds the word from field weights with plain arithmetic.
  function automatic exp_t model(input int op, input int unsigned rdv, input int unsigned r1,
                                 input int unsigned r2, input logic [31:0] immv);
    exp_t e;
    int v;
    int unsigned u;
    v = $signed(immv);
    u = immv;
    e.is_err = 1'b0;
    e.code   = 2'd0;
    e.data   = '0;
    e.addr   = '0;
    case (op)
      0, 1: begin
        if (v < -2048 || v > 2047) e.code = 2'd2;
        else e.data = ((u & 32'hFFF) << 20) | (r1 << 15) | ((op == 1 ? 2 : 0) << 12)
                      | (rdv << 7) | (op == 1 ? 32'h03 : 32'h13);
      end
      2: begin
        if (v < -2048 || v > 2047) e.code = 2'd2;
        else e.data = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
      end
      3: begin
        if (v % 2 != 0) e.code = 2'd3;
        else if (v < -4096 || v > 4094) e.code = 2'd2;
        else e.data = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20)
                      | (r1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      4, 5: e.data = ((op == 5 ? 32'h20 : 32'h0) << 25) | (r2 << 20) | (r1 << 15)
                     | (rdv << 7) | 32'h33;
      default: e.code = 2'd1;
    endcase
    e.is_err = (e.code != 2'd0);
    return e;
  endfunction

  // Present a bundle and wait (bounded) for it to be accepted; returns in the EMIT cycle.
  task automatic issue(input int op, input int rdv, input int r1, input int r2,
                       input logic [31:0] immv, output bit ok);
    bus.op_sel   = op[2:0];
    bus.rd       = rdv[4:0];
    bus.rs1      = r1[4:0];
    bus.rs2      = r2[4:0];
    bus.imm      = immv;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic send(input int op, input int rdv, input int r1, input int r2,
                      input logic [31:0] immv, input bit dir,
                      input logic [31:0] dw, input logic [1:0] dc);
    bit   ok;
    exp_t e;
    issue(op, rdv, r1, r2, immv, ok);
    if (ok) begin
      e = model(op, rdv, r1, r2, immv);
      if (dir) begin
        e.code   = dc;
        e.is_err = (dc != 2'd0);
        e.data   = dw;
      end
      e.addr = model_ptr[AW-1:0];
      if (!e.is_err) begin
        model_ptr = (model_ptr + 1) % DEPTH;
        model_cnt++;
      end
      sb.push_back(e);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    chk("word_count", 32'(bus.word_count), model_cnt);
    chk("full", 32'(bus.full), 32'(model_cnt == DEPTH));
  endtask

  task automatic xfer(input int op, input int rdv, input int r1, input int r2,
                      input logic [31:0] immv);
    send(op, rdv, r1, r2, immv, 1'b0, '0, 2'd0);
    settle();
  endtask

  task automatic dxfer(input int op, input int rdv, input int r1, input int r2,
                       input logic [31:0] immv, input logic [31:0] dw, input logic [1:0] dc);
    send(op, rdv, r1, r2, immv, 1'b1, dw, dc);
    settle();
  endtask

  function automatic logic [31:0] rand_imm();
    int edges[10] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, -4098};
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 9000)) - 32'd4500;
      1: return 32'(edges[$urandom_range(0, 9)]);
      2: return $urandom;
      default: return 32'($urandom_range(0, 1000)) * 2 - 32'd1000;
    endcase
  endfunction

  task automatic rand_xfer();
    xfer($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), rand_imm());
  endtask

  // Monitor: every write or error strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en || bus.err) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: wr_en=%b err=%b addr=%h, expected no output",
                   bus.wr_en, bus.err, bus.wr_addr);
        end else begin
          e = sb.pop_front();
          chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
          if (e.is_err) begin
            chk("err", 32'(bus.err), 32'd1);
            chk("wr_en_on_err", 32'(bus.wr_en), 32'd0);
            chk("err_code", 32'(bus.err_code), 32'(e.code));
          end else begin
            chk("wr_en", 32'(bus.wr_en), 32'd1);
            chk("err_on_write", 32'(bus.err), 32'd0);
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", bus.wr_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    n_chk = 0; n_pass = 0; model_ptr = 0; model_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    bus.op_sel = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_err_code", 32'(bus.err_code), 0);
    chk("rst_word_count", 32'(bus.word_count), 0);
    chk("rst_full", 32'(bus.full), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Documented encodings
    dxfer(0, 1, 0, 0, 32'd5, 32'h00500093, 2'd0);
    dxfer(1, 2, 1, 0, 32'd8, 32'h0080A103, 2'd0);
    dxfer(2, 0, 1, 2, 32'd12, 32'h0020A623, 2'd0);
    dxfer(3, 0, 1, 2, -32'sd8, 32'hFE208CE3, 2'd0);
    dxfer(4, 3, 1, 2, 32'd0, 32'h002081B3, 2'd0);
    dxfer(5, 3, 1, 2, 32'd0, 32'h402081B3, 2'd0);

    // Rejected bundles leave pointer and count alone
    dxfer(0, 1, 0, 0, 32'd2048, '0, 2'b10);
    dxfer(3, 0, 1, 2, 32'd3, '0, 2'b11);
    dxfer(3, 0, 1, 2, 32'd4096, '0, 2'b10);
    dxfer(7, 1, 1, 1, 32'd0, '0, 2'b01);
    xfer(4, 5, 6, 7, 32'd0);
    chk("err_code_held", 32'(bus.err_code), 32'd1);

    for (int i = 0; i < 80; i++) rand_xfer();

    // clear in IDLE blocks acceptance even with in_valid high
    bus.in_valid = 1'b1; bus.op_sel = 3'd0; bus.imm = 32'd1; bus.clear = 1'b1;
    @(negedge clk);
    chk("in_ready_clear", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    model_ptr = 0; model_cnt = 0;
    chk("clear_count", 32'(bus.word_count), 0);
    xfer(0, 4, 4, 0, 32'd100);

    // clear during EMIT: the write still lands at the old pointer, then the count drops to 0
    send(0, 9, 9, 0, 32'd7, 1'b0, '0, 2'd0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    model_ptr = 0; model_cnt = 0;
    chk("clear_emit_count", 32'(bus.word_count), 0);

    // Fill the image to DEPTH
    for (int i = 0; i < 4000 && model_cnt < DEPTH; i++) rand_xfer();
    chk("full_reached", 32'(bus.full), 1);
    bus.in_valid = 1'b1; bus.op_sel = 3'd0; bus.imm = 32'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("in_ready_full", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    model_ptr = 0; model_cnt = 0;
    chk("full_clear_count", 32'(bus.word_count), 0);
    chk("full_clear_full", 32'(bus.full), 0);
    xfer(0, 1, 0, 0, 32'd5);
    xfer(4, 3, 1, 2, 32'd0);

    // Reset landing in EMIT suppresses the write
    issue(0, 1, 0, 0, 32'd5, ok);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_emit_wr_en", 32'(bus.wr_en), 0);
    chk("rst_emit_err", 32'(bus.err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ptr = 0; model_cnt = 0;
    chk("rst_emit_count", 32'(bus.word_count), 0);
    chk("rst_emit_addr", 32'(bus.wr_addr), 0);
    chk("rst_emit_data", bus.wr_data, 0);
    chk("rst_emit_code", 32'(bus.err_code), 0);
    dxfer(0, 1, 0, 0, 32'd5, 32'h00500093, 2'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program-image writer, the inverse of the core's immediate/field decode path. It accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit instruction word, checking immediate legality. Legal words are written into instruction memory at an auto-incrementing word address. It sits between the test/boot loader and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- op_sel  in  3  0 ADDI, 1 LW, 2 SW, 3 BEQ, 4 ADD, 5 SUB, 6–7 illegal
- rd  in  5  destination register; ignored for SW and BEQ
- rs1  in  5  source register 1; ignored by none
- rs2  in  5  source register 2; ignored for ADDI and LW
- imm  in  32  signed immediate or byte offset; ignored for ADD and SUB
- clear  in  1  resets write pointer and count
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_W  word address of the write
- wr_data  out  32  encoded instruction
- err  out  1  one-cycle pulse: bundle rejected
- err_code  out  2  01 illegal op_sel, 10 imm out of range, 11 misaligned branch offset; held until next err
- word_count  out  ADDR_W+1  words written since reset or clear
- full  out  1  word_count == DEPTH

## Operation
- Two-state FSM, IDLE and EMIT.
- In IDLE, in_ready = !full && !clear. An accept (in_valid && in_ready) registers all fields and moves to EMIT.
- In EMIT, in_ready = 0. The encoded word or error is issued, and the FSM returns to IDLE unconditionally.
- Encodings:
  - I-type (ADDI op 0010011 f3 000; LW op 0000011 f3 010): imm[11:0], rs1, f3, rd, op.
  - S-type (SW op 0100011 f3 010): imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - B-type (BEQ op 1100011 f3 000): imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - R-type (op 0110011 f3 000): funct7, rs2, rs1, f3, rd, op. ADD funct7 = 0000000; SUB funct7 = 0100000.
- Legality checks on the full 32-bit signed imm:
  - I and S: −2048..2047.
  - B: −4096..4094, and imm[0] must be 0.
  - Priority: illegal op_sel, then misaligned (B only), then range.
- Legal bundle: wr_en = 1, wr_addr = pointer, wr_data = word. The pointer increments modulo DEPTH and word_count increments.
- Illegal bundle: wr_en = 0, err = 1, err_code set. Pointer and count are unchanged.
- clear:
  - In IDLE, pointer and word_count go to 0 next cycle, and no accept occurs that cycle.
  - In EMIT, the pending write is still issued at the old pointer, then pointer and count go to 0. clear wins over increment.
- full blocks acceptance. Only clear or reset releases it; there is no overwrite.

## Timing
- Reset (rst_n low at a rising edge): state IDLE; pointer 0; word_count 0; full 0; wr_en 0; wr_addr 0; wr_data 0; err 0; err_code 00. in_ready = 1 once rst_n is high.
- Latency: accept at edge N; wr_en/err valid during cycle N+1 (registered outputs).
- Throughput: one bundle per 2 cycles.
- wr_addr and wr_data are stable for the whole cycle wr_en is high. wr_data holds its last value otherwise.
- Reset while in EMIT: no write or err is issued; all state returns to reset values.
- word_count and full update on the edge that ends the EMIT cycle.

## Test plan
- Reset then ADDI rd=1 rs1=0 imm=5 → one cycle after accept, wr_en=1, wr_addr=0, wr_data=0x00500093; word_count=1.
- LW rd=2 rs1=1 imm=8, then SW rs2=2 rs1=1 imm=12 → 0x0080A103 at addr 1 and 0x0020A623 at addr 2; in_ready=0 in each EMIT cycle.
- BEQ rs1=1 rs2=2 imm=−8 → 0xFE208CE3. ADD rd=3 rs1=1 rs2=2 → 0x002081B3. SUB with the same fields → 0x402081B3.
- Error cases, each with err pulse, wr_en=0 and pointer unchanged:
  - ADDI imm=2048 → err_code 10.
  - BEQ imm=3 → err_code 11.
  - BEQ imm=4096 → err_code 10.
  - op_sel=7 → err_code 01.
- ADDR_W=2: four legal writes → addr 0..3, full=1, in_ready=0, with in_valid held high and no further writes. Assert clear → word_count=0, full=0; next write lands at addr 0.
- Drive rst_n low during EMIT → no wr_en that cycle. All outputs reach reset values, and the next accepted ADDI writes to addr 0.
